// File: rtl/fetch_sequencer.sv
// Fetch-stage control for the 16-bit MIPS core: drives PC mux, redirect
// address, PC/program-memory stalls and IF/ID flush from pipeline events.
module fetch_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int MC_CNT_WIDTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    jump_req,
   input  logic [ADDR_WIDTH-1:0]   jump_target,
   input  logic                    load_use_hazard,
   input  logic                    mc_start,
   input  logic [MC_CNT_WIDTH-1:0] mc_cycles,
   input  logic                    halt_req,
   input  logic                    resume,
   output logic                    pc_mux_sel,
   output logic [ADDR_WIDTH-1:0]   jmp_loc,
   output logic                    stall,
   output logic                    stall_pm,
   output logic                    flush,
   output logic                    busy,
   output logic [15:0]             stall_count
);

   typedef enum logic [2:0] {
      BOOT, RUN, FLUSH, BUBBLE, MULTI, HALT
   } state_t;

   state_t                  state, state_nx;
   logic [MC_CNT_WIDTH-1:0] cnt, cnt_nx;
   logic [ADDR_WIDTH-1:0]   jmp_nx;
   logic                    mc_ok;

   // A zero-length multi-cycle op falls through to the next request.
   assign mc_ok = mc_start && (mc_cycles != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= BOOT;
         cnt     <= '0;
         jmp_loc <= RESET_VECTOR;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         jmp_loc <= jmp_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      jmp_nx   = jmp_loc;
      unique case (state)
         BOOT:   state_nx = RUN;
         RUN: begin
            if (halt_req) begin
               state_nx = HALT;
            end else if (jump_req) begin
               state_nx = FLUSH;
               jmp_nx   = jump_target;
            end else if (mc_ok) begin
               state_nx = MULTI;
               cnt_nx   = mc_cycles;
            end else if (load_use_hazard) begin
               state_nx = BUBBLE;
            end
         end
         FLUSH:  state_nx = RUN;
         BUBBLE: state_nx = RUN;
         MULTI: begin
            cnt_nx = cnt - 1'b1;
            if (cnt == MC_CNT_WIDTH'(1)) state_nx = RUN;
         end
         HALT:   if (resume) state_nx = RUN;
         default: state_nx = BOOT;
      endcase
   end

   // Outputs decode straight from the state register, so they are glitch-free.
   assign pc_mux_sel = (state == BOOT) || (state == FLUSH);
   assign flush      = (state == BOOT) || (state == FLUSH) || (state == HALT);
   assign stall      = (state == BUBBLE) || (state == MULTI) || (state == HALT);
   assign stall_pm   = (state == BUBBLE) || (state == MULTI);
   assign busy       = (state != RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected output vectors are queued
// as stimulus is applied and matched against captured outputs.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        jump_req;
   logic [15:0] jump_target;
   logic        load_use_hazard;
   logic        mc_start;
   logic [3:0]  mc_cycles;
   logic        halt_req;
   logic        resume;
   logic        pc_mux_sel;
   logic [15:0] jmp_loc;
   logic        stall;
   logic        stall_pm;
   logic        flush;
   logic        busy;
   logic [15:0] stall_count;

   typedef struct packed {
      logic        pc;
      logic        st;
      logic        sp;
      logic        fl;
      logic        bz;
      logic [15:0] jl;
      logic [15:0] sc;
   } vec_t;

   vec_t sbq[$];
   vec_t obsq[$];
   vec_t obs;
   int   checks = 0;
   int   failures = 0;
   logic [15:0] jl;
   logic [15:0] sc;

   fetch_sequencer dut (
      .clk(clk),
      .reset(reset),
      .jump_req(jump_req),
      .jump_target(jump_target),
      .load_use_hazard(load_use_hazard),
      .mc_start(mc_start),
      .mc_cycles(mc_cycles),
      .halt_req(halt_req),
      .resume(resume),
      .pc_mux_sel(pc_mux_sel),
      .jmp_loc(jmp_loc),
      .stall(stall),
      .stall_pm(stall_pm),
      .flush(flush),
      .busy(busy),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   assign obs = {pc_mux_sel, stall, stall_pm, flush, busy,
                 jmp_loc, stall_count};

   function automatic vec_t ex(logic p, logic s, logic sp,
                               logic f, logic b);
      return {p, s, sp, f, b, jl, sc};
   endfunction

   function automatic vec_t e_run();  return ex(0, 0, 0, 0, 0); endfunction
   function automatic vec_t e_fl();   return ex(1, 0, 0, 1, 1); endfunction
   function automatic vec_t e_stl();  return ex(0, 1, 1, 0, 1); endfunction
   function automatic vec_t e_halt(); return ex(0, 1, 0, 1, 1); endfunction

   task automatic idle();
      jump_req = 0; jump_target = '0; load_use_hazard = 0;
      mc_start = 0; mc_cycles = '0; halt_req = 0; resume = 0;
   endtask

   // Queue expectation, advance one edge, capture the resulting outputs.
   task automatic step(vec_t e);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      obsq.push_back(obs);
      if (e.st) sc = sc + 16'd1;
   endtask

   task automatic test_reset();
      int n = 0;
      vec_t e, o;
      idle();
      reset = 1;
      jl = 16'h0000;
      sc = 16'h0000;
      repeat (3) step(e_fl());
      reset = 0;
      step(e_run());
      step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL reset[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_jump();
      int n = 0;
      vec_t e, o;
      jump_req = 1; jump_target = 16'h0008;
      jl = 16'h0008;
      step(e_fl());
      idle();
      step(e_run());
      // priority: jump wins over multi-cycle and hazard
      jump_req = 1; jump_target = 16'h0020;
      mc_start = 1; mc_cycles = 4'd3; load_use_hazard = 1;
      jl = 16'h0020;
      step(e_fl());
      idle();
      step(e_run());
      step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL jump[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      vec_t e, o;
      jump_req = 1; jump_target = 16'h0030;
      jl = 16'h0030;
      step(e_fl());
      jump_target = 16'h0040;
      step(e_run());
      jl = 16'h0040;
      step(e_fl());
      idle();
      step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL b2b[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_multi();
      int n = 0;
      vec_t e, o;
      mc_start = 1; mc_cycles = 4'd4;
      step(e_stl());
      idle();
      jump_req = 1; jump_target = 16'h0055;
      repeat (3) step(e_stl());
      idle();
      step(e_run());
      // zero-length op is ignored
      mc_start = 1; mc_cycles = 4'd0;
      step(e_run());
      // zero-length op falls through to the hazard
      load_use_hazard = 1;
      step(e_stl());
      idle();
      step(e_run());
      // maximum length
      mc_start = 1; mc_cycles = 4'd15;
      step(e_stl());
      idle();
      repeat (14) step(e_stl());
      step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL multi[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_bubble();
      int n = 0;
      vec_t e, o;
      load_use_hazard = 1;
      step(e_stl());
      idle();
      step(e_run());
      step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL bubble[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_halt();
      int n = 0;
      vec_t e, o;
      halt_req = 1; jump_req = 1; jump_target = 16'h0099;
      step(e_halt());
      idle();
      jump_req = 1; jump_target = 16'h0077;
      repeat (5) step(e_halt());
      idle();
      resume = 1;
      step(e_run());
      step(e_run());
      resume = 0;
      step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL halt[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      vec_t e, o;
      mc_start = 1; mc_cycles = 4'd10;
      step(e_stl());
      idle();
      repeat (2) step(e_stl());
      reset = 1;
      jl = 16'h0000;
      sc = 16'h0000;
      step(e_fl());
      reset = 0;
      repeat (3) step(e_run());
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         o = obsq.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL rstmid[%0d] got=%h exp=%h", n, o, e);
         end
         n++;
      end
   endtask

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_jump();
      test_back_to_back();
      test_multi();
      test_bubble();
      test_halt();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control unit that drives the program-memory fetch stage of the 16-bit MIPS core: it generates `pc_mux_sel`, `jmp_loc`, `stall` and `stall_pm` for the program memory from pipeline events. These events are jumps/branches, load-use hazards, multi-cycle execute operations, HALT and a reset-vector boot. It sits between decode/execute hazard logic and the program memory, and also issues the IF/ID flush (bubble) signal.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of program addresses (`jmp_loc`, `jump_target`)
- `MC_CNT_WIDTH`, 4, width of multi-cycle stall length
- `RESET_VECTOR`, 16'h0000, first fetch address after reset

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `jump_req`  in  1  taken jump/branch resolved this cycle
- `jump_target`  in  ADDR_WIDTH  target address, valid with `jump_req`
- `load_use_hazard`  in  1  decode detected load-use dependency
- `mc_start`  in  1  multi-cycle execute op begins
- `mc_cycles`  in  MC_CNT_WIDTH  extra cycles the op needs, valid with `mc_start`
- `halt_req`  in  1  HALT instruction decoded
- `resume`  in  1  leave HALT
- `pc_mux_sel`  out  1  1 = next PC is `jmp_loc`, 0 = PC+1
- `jmp_loc`  out  ADDR_WIDTH  redirect address to program memory
- `stall`  out  1  hold PC
- `stall_pm`  out  1  hold program-memory instruction output register
- `flush`  out  1  insert NOP into IF/ID
- `busy`  out  1  state != RUN
- `stall_count`  out  16  saturating count of cycles with `stall`=1

## Operation
- States: BOOT, RUN, FLUSH, BUBBLE, MULTI, HALT. All outputs are registered and derived from state plus latched registers.
- BOOT: `pc_mux_sel`=1, `jmp_loc`=RESET_VECTOR, `flush`=1, `stall`=`stall_pm`=0. Lasts exactly one cycle after reset is released, then RUN.
- RUN: all control outputs 0 (`jmp_loc` keeps its last value). Requests are sampled at each edge with fixed priority `halt_req` > `jump_req` > `mc_start` > `load_use_hazard`. Lower-priority simultaneous requests are dropped.
  - `halt_req` -> HALT.
  - `jump_req` -> FLUSH; latches `jmp_loc` <= `jump_target`.
  - `mc_start` with `mc_cycles`=N>0 -> MULTI; counter <= N. With N=0, `mc_start` is ignored and the next lower request is evaluated.
  - `load_use_hazard` -> BUBBLE.
- FLUSH: `pc_mux_sel`=1, `flush`=1, `stall`=`stall_pm`=0. Lasts one cycle, then RUN.
- BUBBLE: `stall`=1, `stall_pm`=1, `flush`=0. Lasts one cycle, then RUN. `load_use_hazard` is not re-sampled here, so one bubble is inserted per hazard.
- MULTI: `stall`=1, `stall_pm`=1. The counter decrements each cycle, and the state returns to RUN on the edge where counter = 1, giving exactly N stall cycles. All requests are ignored in MULTI; upstream holds them stable.
- HALT: `stall`=1, `stall_pm`=0, `flush`=1, so NOPs are fed downstream. Exits to RUN on the edge where `resume`=1. Other requests are ignored. `resume` outside HALT has no effect.
- `busy` = 1 in every state except RUN.
- `stall_count` increments on every cycle with `stall`=1 and saturates at 16'hFFFF.

## Timing
- Reset (synchronous, active-high) on any edge, including mid-MULTI or HALT, forces state BOOT and sets:
  - `pc_mux_sel`=1, `jmp_loc`=RESET_VECTOR, `flush`=1
  - `stall`=0, `stall_pm`=0, `busy`=1
  - `stall_count`=0, counter=0
- BOOT persists while `reset` is held.
- Latency: a request sampled at edge k produces its outputs during cycle k+1 (one-cycle registered latency).
  - FLUSH: program memory loads `jmp_loc` at edge k+2.
  - BUBBLE: one cycle of stall.
  - MULTI: N cycles of stall; RUN resumes at edge k+1+N.
  - HALT: persists until the edge on which `resume` is sampled; RUN in the following cycle.
- Back-to-back: a jump sampled in the RUN cycle immediately after FLUSH is accepted normally (FLUSH -> RUN -> FLUSH, minimum 2-cycle spacing).
- The counter decrements mod 2^MC_CNT_WIDTH but never passes 1 because of the exit rule. `mc_cycles`=max (15) gives 15 stall cycles.

## Test plan
- Reset: hold `reset`=1 for 3 cycles, release. Expect `pc_mux_sel`=1, `jmp_loc`=16'h0000, `flush`=1 through the first cycle after release, then all outputs 0 and `busy`=0.
- Jump: in RUN, pulse `jump_req` with `jump_target`=16'h0008. Expect exactly one cycle of `pc_mux_sel`=1, `flush`=1, `jmp_loc`=16'h0008, then RUN with `jmp_loc` still 16'h0008.
- Priority: in one cycle assert `jump_req` (16'h0020), `mc_start` (N=3) and `load_use_hazard`. Expect FLUSH only: no stall cycles, `stall_count` unchanged.
- Multi-cycle: `mc_start` with `mc_cycles`=4. Expect `stall`=`stall_pm`=1 for exactly 4 cycles and `stall_count`=4. A `jump_req` during the stall is ignored. `mc_cycles`=0 produces no stall.
- Halt/resume: `halt_req`, wait 5 cycles, pulse `resume`. Expect `stall`=1, `flush`=1, `stall_pm`=0 for 5+ cycles, then RUN. `resume` in RUN has no effect.
- Reset mid-operation: `mc_start` with N=10, assert `reset` after 3 stall cycles. Expect BOOT outputs next cycle, `stall_count`=0, and no further stalls after release.
